// File: rtl/sum_bcd_conv.sv
// sum_bcd_conv: signed adder result to sign + three BCD digits via iterative double-dabble
module sum_bcd_conv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] s_in,
  input  logic             cout_in,
  input  logic             sel_in,
  output logic             busy,
  output logic             done,
  output logic             neg,
  output logic [3:0]       bcd2,
  output logic [3:0]       bcd1,
  output logic [3:0]       bcd0
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  localparam logic [WIDTH:0] FULL = {1'b1, {WIDTH{1'b0}}};
  logic [0:0] state;
  logic [WIDTH:0] mag, mag_in;
  logic [10:0] acc, adj;
  logic [11:0] nxt;
  logic [3:0] count;
  logic sign, sign_in;
  // hundreds digit never exceeds 5 for a 9-bit magnitude, so 3 bits hold it during conversion
  always_comb begin
    sign_in = sel_in & ~cout_in;
    mag_in = !sel_in ? {cout_in, s_in} : cout_in ? {1'b0, s_in} : FULL - {1'b0, s_in};
    adj[3:0] = acc[3:0] + (acc[3:0] >= 4'd5 ? 4'd3 : 4'd0);
    adj[7:4] = acc[7:4] + (acc[7:4] >= 4'd5 ? 4'd3 : 4'd0);
    adj[10:8] = acc[10:8] + (acc[10:8] >= 3'd5 ? 3'd3 : 3'd0);
    nxt = {adj, mag[WIDTH]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      neg <= 1'b0;
      bcd2 <= 4'd0;
      bcd1 <= 4'd0;
      bcd0 <= 4'd0;
      mag <= '0;
      acc <= '0;
      count <= 4'd0;
      sign <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          sign <= sign_in;
          mag <= mag_in;
          acc <= '0;
          count <= 4'(WIDTH + 1);
          busy <= 1'b1;
          state <= SHIFT;
        end
      end else begin
        acc <= nxt[10:0];
        mag <= {mag[WIDTH-1:0], 1'b0};
        count <= count - 4'd1;
        if (count == 4'd1) begin
          bcd2 <= nxt[11:8];
          bcd1 <= nxt[7:4];
          bcd0 <= nxt[3:0];
          neg <= sign;
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end
endmodule
